// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I control fields into 32-bit words with sequential addresses.
// Define INSTR_ENC_ALIGN_CHECK_EN to reject odd BRANCH/JAL offsets with error code 3.
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [7:0]        err_count,
  output logic              done
);
  typedef enum logic {RUN, DONE} state_t;
  localparam logic [31:0] EBREAK_WORD = 32'h00100073;
  state_t state, state_nx;
  logic [31:0] enc;
  logic [2:0] err;
  logic [6:0] funct7;
  logic acc, out_hs, halt_hs, shift, i_ok, b_ok, j_ok, mis;
  assign acc = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign halt_hs = out_hs && out_instr == EBREAK_WORD;
  assign shift = in_funct3 == 3'd1 || in_funct3 == 3'd5;
  assign funct7 = {1'b0, in_alt, 5'b0};
  // an immediate fits when all bits above the field's sign bit match it
  assign i_ok = &in_imm[31:11] || ~|in_imm[31:11];
  assign b_ok = &in_imm[31:12] || ~|in_imm[31:12];
  assign j_ok = &in_imm[31:20] || ~|in_imm[31:20];
`ifdef INSTR_ENC_ALIGN_CHECK_EN
  assign mis = in_imm[0];
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    enc = '0;
    err = '0;
    case (in_class)
      3'd0: begin
        enc = {funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        err = (in_alt && in_funct3 != 3'd0 && in_funct3 != 3'd5) ? 3'd2 : 3'd0;
      end
      3'd1: begin
        enc = shift ? {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011}
                    : {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        err = (in_alt && (!shift || in_funct3 == 3'd1)) ? 3'd2 :
              (shift ? |in_imm[31:5] : !i_ok) ? 3'd1 : 3'd0;
      end
      3'd2: begin
        enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        err = (in_funct3 == 3'd3 || in_funct3[2:1] == 2'b11) ? 3'd2 : !i_ok ? 3'd1 : 3'd0;
      end
      3'd3: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        err = (in_funct3 > 3'd2) ? 3'd2 : !i_ok ? 3'd1 : 3'd0;
      end
      3'd4: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
        err = (in_funct3[2:1] == 2'b01) ? 3'd2 : !b_ok ? 3'd1 : mis ? 3'd3 : 3'd0;
      end
      3'd5: begin
        enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        err = !j_ok ? 3'd1 : mis ? 3'd3 : 3'd0;
      end
      3'd6: enc = EBREAK_WORD;
      default: err = 3'd4;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nx;
  always_comb state_nx = (state == DONE) ? (start ? RUN : DONE) : (halt_hs && !start ? DONE : RUN);
  always_comb begin
    done = state == DONE;
    in_ready = state == RUN && (!out_valid || out_ready);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr <= BASE_ADDR;
      err_valid <= 1'b0;
      err_code <= '0;
      err_count <= '0;
    end else begin
      out_valid <= (acc && err == 3'd0) ? 1'b1 : out_hs ? 1'b0 : out_valid;
      if (acc && err == 3'd0) out_instr <= enc;
      // start wins over the address step, including on the EBREAK handshake itself
      if (start && (state == DONE || halt_hs)) out_addr <= BASE_ADDR;
      else if (out_hs) out_addr <= out_addr + ADDR_W'(4);
      err_valid <= acc && err != 3'd0;
      if (acc) err_code <= err;
      if (acc && err != 3'd0 && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written handshake, halt and reset sequences.
module tb_instr_encoder;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, in_ready, in_alt = 0, out_valid, out_ready = 1;
  logic err_valid, done;
  logic [2:0] in_class = 0, in_funct3 = 0, err_code;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_instr, out_addr;
  logic [7:0] err_count;
  int pass_cnt = 0, total = 0, ecnt = 0;
  logic [31:0] exp_addr = 0;
  typedef struct {
    logic [2:0] cls; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic alt;
    logic [31:0] imm; logic [2:0] err; logic [31:0] instr;
  } vec_t;
  vec_t vecs[$];
  vec_t ill, add_v, addi_v, sw_v, ebk_v;
`ifdef INSTR_ENC_ALIGN_CHECK_EN
  localparam logic [2:0] ODD_ERR = 3'd3;
`else
  localparam logic [2:0] ODD_ERR = 3'd0;
`endif

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .err_valid(err_valid),
    .err_code(err_code), .err_count(err_count), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_class = v.cls; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_alt = v.alt; in_imm = v.imm; in_valid = 1;
  endtask

  // call in the negedge phase; returns #1 after the accepting edge
  task automatic send(input vec_t v);
    int n = 0;
    drive(v);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end
    @(posedge clk); #1 in_valid = 0;
  endtask

  initial begin
    vecs.push_back(vec_t'{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 3'd0, 32'h002081B3});
    vecs.push_back(vec_t'{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 3'd0, 32'h402081B3});
    vecs.push_back(vec_t'{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd1, 3'd0, 32'hFFF00093});
    vecs.push_back(vec_t'{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 3'd1, 32'h0});
    vecs.push_back(vec_t'{3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 3'd0, 32'h0020A423});
    vecs.push_back(vec_t'{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4, 3'd0, 32'hFE208EE3});
    vecs.push_back(vec_t'{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 3'd0, 32'h008000EF});
    vecs.push_back(vec_t'{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd5, ODD_ERR, 32'h00208263});
    vecs.push_back(vec_t'{3'd1, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'd3, 3'd0, 32'h40335293});
    vecs.push_back(vec_t'{3'd2, 5'd4, 5'd2, 5'd0, 3'd2, 1'b0, -32'sd8, 3'd0, 32'hFF812203});
    vecs.push_back(vec_t'{3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 3'd4, 32'h0});
    vecs.push_back(vec_t'{3'd0, 5'd3, 5'd1, 5'd2, 3'd1, 1'b1, 32'd0, 3'd2, 32'h0});
    vecs.push_back(vec_t'{3'd1, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd32, 3'd1, 32'h0});
    vecs.push_back(vec_t'{3'd3, 5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'd5000, 3'd2, 32'h0});
    vecs.push_back(vec_t'{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096, 3'd1, 32'h0});
    vecs.push_back(vec_t'{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048576, 3'd1, 32'h0});
    vecs.push_back(vec_t'{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b1, 32'd1, 3'd2, 32'h0});
    vecs.push_back(vec_t'{3'd2, 5'd1, 5'd0, 5'd0, 3'd6, 1'b0, 32'd0, 3'd2, 32'h0});
    vecs.push_back(vec_t'{3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd1048576, 3'd0, 32'h8000006F});
    vecs.push_back(vec_t'{3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2047, 3'd0, 32'h7FF00093});
    vecs.push_back(vec_t'{3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4094, 3'd0, 32'h7E000FE3});
    ill = vecs[10]; add_v = vecs[0]; addi_v = vecs[2]; sw_v = vecs[4];
    ebk_v = vec_t'{3'd6, 5'd7, 5'd9, 5'd11, 3'd5, 1'b1, 32'hDEAD, 3'd0, 32'h00100073};

    #1 rst = 1;
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_instr", out_instr, 0);
    chk("rst out_addr", out_addr, 0);
    chk("rst err_valid", err_valid, 0);
    chk("rst err_code", err_code, 0);
    chk("rst err_count", err_count, 0);
    chk("rst done", done, 0);
    rst = 0;
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      send(vecs[i]);
      @(negedge clk);
      if (vecs[i].err == 3'd0) begin
        chk($sformatf("v%0d out_valid", i), out_valid, 1);
        chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].instr);
        chk($sformatf("v%0d out_addr", i), out_addr, exp_addr);
        chk($sformatf("v%0d err_code", i), err_code, 0);
        exp_addr += 4;
      end else begin
        ecnt++;
        chk($sformatf("v%0d err_valid", i), err_valid, 1);
        chk($sformatf("v%0d err_code", i), err_code, vecs[i].err);
        chk($sformatf("v%0d out_valid", i), out_valid, 0);
        chk($sformatf("v%0d out_addr", i), out_addr, exp_addr);
        chk($sformatf("v%0d err_count", i), err_count, ecnt);
      end
    end
    @(negedge clk);
    chk("err_valid one pulse", err_valid, 0);

    out_ready = 0;
    send(add_v);
    @(negedge clk);
    chk("bp first valid", out_valid, 1);
    drive(addi_v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d out_instr", k), out_instr, add_v.instr);
      chk($sformatf("bp%0d out_addr", k), out_addr, exp_addr);
    end
    out_ready = 1;
    @(posedge clk); #1 drive(sw_v);
    @(negedge clk);
    chk("b2b word2 instr", out_instr, addi_v.instr);
    chk("b2b word2 addr", out_addr, exp_addr + 4);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("b2b word3 instr", out_instr, sw_v.instr);
    chk("b2b word3 addr", out_addr, exp_addr + 8);
    chk("b2b word3 valid", out_valid, 1);
    @(negedge clk);
    exp_addr += 12;
    chk("b2b drained", out_valid, 0);
    chk("b2b final addr", out_addr, exp_addr);

    start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("start in RUN addr", out_addr, exp_addr);
    chk("start in RUN done", done, 0);

    send(ebk_v);
    @(negedge clk);
    chk("ebreak instr", out_instr, 32'h00100073);
    chk("ebreak addr", out_addr, exp_addr);
    drive(add_v);
    @(negedge clk);
    chk("halt done", done, 1);
    chk("halt in_ready", in_ready, 0);
    @(negedge clk);
    chk("halt no output", out_valid, 0);
    in_valid = 0;
    start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("restart done", done, 0);
    chk("restart addr", out_addr, 0);
    send(add_v);
    @(negedge clk);
    chk("restart word addr", out_addr, 0);
    chk("restart word instr", out_instr, add_v.instr);
    @(negedge clk);

    out_ready = 0;
    send(ebk_v);
    @(negedge clk);
    chk("sim ebreak valid", out_valid, 1);
    start = 1; out_ready = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("sim start done", done, 0);
    chk("sim start addr", out_addr, 0);
    chk("sim start in_ready", in_ready, 1);

    for (int k = 0; k < 250; k++) begin
      send(ill);
      if (ecnt < 255) ecnt++;
    end
    @(negedge clk);
    chk("err_count saturate", err_count, ecnt);

    out_ready = 0;
    send(add_v);
    @(negedge clk);
    chk("pre-rst valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_instr", out_instr, 0);
    chk("async rst out_addr", out_addr, 0);
    chk("async rst err_count", err_count, 0);
    chk("async rst err_code", err_code, 0);
    chk("async rst done", done, 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
